// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache: 8 sets of 4-byte blocks.
// Byte-wide CPU port, 32-bit block-wide memory port, and a single-FSM miss handler.
module dcache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t      state;
  logic [31:0] data_mem [8];
  logic [2:0]  tag_mem  [8];
  logic [7:0]  valid;
  logic [7:0]  dirty;

  logic [2:0] addr_tag;
  logic [2:0] idx;
  logic [1:0] off;
  logic       access;
  logic       hit;

  assign addr_tag = ADDRESS[7:5];
  assign idx      = ADDRESS[4:2];
  assign off      = ADDRESS[1:0];
  assign access   = READ | WRITE;
  assign hit      = valid[idx] & (tag_mem[idx] == addr_tag);

  assign READDATA = data_mem[idx][{off, 3'b000} +: 8];
  assign BUSYWAIT = (access & ~hit & (state == IDLE)) | (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      for (int i = 0; i < 8; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (access && hit) begin
            // READ wins when both strobes are high, so the store is suppressed
            if (WRITE && !READ) begin
              data_mem[idx][{off, 3'b000} +: 8] <= WRITEDATA;
              dirty[idx]                        <= 1'b1;
            end
          end else if (access) begin
            if (valid[idx] && dirty[idx]) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_mem[idx], idx};
              MEM_WRITEDATA <= data_mem[idx];
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {addr_tag, idx};
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state       <= FETCH;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {addr_tag, idx};
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state         <= IDLE;
            MEM_READ      <= 1'b0;
            data_mem[idx] <= MEM_READDATA;
            tag_mem[idx]  <= addr_tag;
            valid[idx]    <= 1'b1;
            dirty[idx]    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          MEM_READ  <= 1'b0;
          MEM_WRITE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a small latency-programmable block memory.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  address, writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait = 1'b0;

  logic [31:0] memory [64];
  int          lat  = 3;
  bit          hold = 1'b0;
  int          cnt  = 0;
  logic [1:0]  last_req = 2'b00;

  int n_checks = 0;
  int n_fail   = 0;
  bit saw_write;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .CLK(clk), .RESET(reset), .READ(read), .WRITE(write),
    .ADDRESS(address), .WRITEDATA(writedata), .READDATA(readdata),
    .BUSYWAIT(busywait), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
    .MEM_ADDRESS(mem_address), .MEM_WRITEDATA(mem_writedata),
    .MEM_READDATA(mem_readdata), .MEM_BUSYWAIT(mem_busywait)
  );

  assign mem_readdata = memory[mem_address];

  // Memory: captures write-backs at the completing edge, then updates its busy line
  always @(posedge clk) begin
    if (mem_write && !mem_busywait) memory[mem_address] = mem_writedata;
    #2;
    if (hold) mem_busywait = 1'b1;
    else if (!(mem_read || mem_write)) begin
      cnt = 0;
      mem_busywait = 1'b0;
    end else if ({mem_read, mem_write} != last_req) begin
      cnt = 1;
      mem_busywait = (lat > 0);
    end else if (cnt < lat) begin
      cnt++;
      mem_busywait = 1'b1;
    end else mem_busywait = 1'b0;
    last_req = {mem_read, mem_write};
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    read = r; write = w; address = a; writedata = d;
    #1;
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    while (busywait && n < 60) begin
      if (mem_write) saw_write = 1'b1;
      tick();
      #1;
      n++;
    end
    if (busywait) check_val({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_mem_read(input string tag);
    int n = 0;
    while (!mem_read && n < 60) begin
      tick();
      #1;
      n++;
    end
    if (!mem_read) check_val({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) memory[i] = {8'(i), 8'(i), 8'(i), 8'(i)};
    memory[6'h09] = 32'h4433_2211;
    memory[6'h11] = 32'h8877_6655;
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick(); tick();
    reset = 1'b0;
    #1;
    check_val("rst_readdata", 32'(readdata), 32'h0);
    check_val("rst_busywait", 32'(busywait), 32'h0);
    check_val("rst_mem_req", {30'd0, mem_read, mem_write}, 32'h0);
    check_val("rst_mem_addr", 32'(mem_address), 32'h0);
    check_val("rst_mem_wdata", mem_writedata, 32'h0);

    // Cold read miss on 0x25
    saw_write = 1'b0;
    drive(1'b1, 1'b0, 8'h25, 8'h00);
    check_val("miss_busy_now", 32'(busywait), 32'h1);
    tick(); #1;
    check_val("fetch_mem_read", 32'(mem_read), 32'h1);
    check_val("fetch_mem_addr", 32'(mem_address), 32'h09);
    if (mem_write) saw_write = 1'b1;
    wait_not_busy("miss1");
    check_val("miss1_readdata", 32'(readdata), 32'h22);
    check_val("miss1_no_mem_write", 32'(saw_write), 32'h0);
    tick();

    // Read hit on the same block
    drive(1'b1, 1'b0, 8'h24, 8'h00);
    check_val("hit_busy", 32'(busywait), 32'h0);
    check_val("hit_readdata", 32'(readdata), 32'h11);
    check_val("hit_no_mem_read", 32'(mem_read), 32'h0);
    tick();

    // Write hit then read back
    drive(1'b0, 1'b1, 8'h26, 8'hAB);
    check_val("whit_busy", 32'(busywait), 32'h0);
    tick();
    drive(1'b1, 1'b0, 8'h26, 8'h00);
    check_val("whit_readback", 32'(readdata), 32'hAB);
    tick();

    // Conflict miss on dirty set 1: write-back then fetch
    drive(1'b1, 1'b0, 8'h46, 8'h00);
    check_val("conf_busy", 32'(busywait), 32'h1);
    tick(); #1;
    check_val("wb_mem_write", 32'(mem_write), 32'h1);
    check_val("wb_mem_read", 32'(mem_read), 32'h0);
    check_val("wb_mem_addr", 32'(mem_address), 32'h09);
    check_val("wb_mem_wdata", mem_writedata, 32'h44AB_2211);
    wait_mem_read("wb");
    check_val("fetch2_mem_addr", 32'(mem_address), 32'h11);
    check_val("fetch2_mem_write", 32'(mem_write), 32'h0);
    wait_not_busy("miss2");
    check_val("miss2_readdata", 32'(readdata), 32'h77);
    check_val("wb_mem_stored", memory[6'h09], 32'h44AB_2211);
    tick();

    // Reset in the middle of a stalled fetch
    hold = 1'b1;
    drive(1'b1, 1'b0, 8'h25, 8'h00);
    check_val("hold_busy", 32'(busywait), 32'h1);
    tick(); tick(); tick(); #1;
    check_val("hold_mem_read", 32'(mem_read), 32'h1);
    check_val("hold_mem_addr", 32'(mem_address), 32'h09);
    reset = 1'b1;
    hold  = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_val("midrst_mem_read", 32'(mem_read), 32'h0);
    check_val("midrst_mem_addr", 32'(mem_address), 32'h0);
    check_val("midrst_busy", 32'(busywait), 32'h1);
    check_val("midrst_readdata", 32'(readdata), 32'h0);
    tick(); #1;
    check_val("restart_mem_read", 32'(mem_read), 32'h1);
    check_val("restart_mem_addr", 32'(mem_address), 32'h09);
    wait_not_busy("restart");
    check_val("restart_readdata", 32'(readdata), 32'h22);
    tick();

    // READ and WRITE together on a hit behave as a read
    drive(1'b1, 1'b1, 8'h25, 8'hEE);
    check_val("rw_busy", 32'(busywait), 32'h0);
    check_val("rw_readdata", 32'(readdata), 32'h22);
    tick();
    drive(1'b1, 1'b0, 8'h25, 8'h00);
    check_val("rw_unchanged", 32'(readdata), 32'h22);
    tick();
    drive(1'b1, 1'b0, 8'h45, 8'h00);
    tick(); #1;
    check_val("rw_clean_no_wb", 32'(mem_write), 32'h0);
    check_val("rw_clean_fetch", 32'(mem_read), 32'h1);
    check_val("rw_clean_addr", 32'(mem_address), 32'h11);
    wait_not_busy("miss3");
    check_val("miss3_readdata", 32'(readdata), 32'h66);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU datapath and main data memory.
- Its READDATA output feeds the write-data mux in front of the 8x8 register file (load path).
- Its BUSYWAIT output stalls the CPU while a miss is serviced.
- Geometry: 8 blocks x 4 bytes. CPU side is byte-wide; memory side is block-wide (32 bits).

Parameters:
- None. The geometry is fixed at 8 sets, 4-byte blocks, 3-bit tag, and 6-bit block address.
- Any change to the geometry requires changes to the port widths.

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-high reset
READ  in  1  CPU load request, held until BUSYWAIT low
WRITE  in  1  CPU store request, held until BUSYWAIT low
ADDRESS  in  8  byte address: [7:5] tag, [4:2] index, [1:0] offset
WRITEDATA  in  8  store byte
READDATA  out  8  load byte (to register-file write mux)
BUSYWAIT  out  1  CPU stall
MEM_READ  out  1  memory block read request
MEM_WRITE  out  1  memory block write request
MEM_ADDRESS  out  6  block address {tag,index}
MEM_WRITEDATA  out  32  block being written back; byte k = bits [8k+7:8k]
MEM_READDATA  in  32  fetched block, same byte order
MEM_BUSYWAIT  in  1  memory busy; sampled only at posedge

Behaviour:
- Per-set storage: data[31:0], tag[2:0], valid, dirty.
- hit = valid[index] & (tag[index] == ADDRESS[7:5]).
- Reset (RESET=1 at posedge, takes priority over everything, including mid-miss):
  - all valid, dirty, tag and data cleared to 0; state goes to IDLE.
  - MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - READDATA=0 after reset.
  - An access still asserted after reset is treated as a fresh miss.
- READDATA:
  - Combinational: the byte of data[index] selected by the offset.
  - Valid to the CPU whenever READ=1 and BUSYWAIT=0.
- BUSYWAIT:
  - Combinational: ((READ|WRITE) & ~hit & state==IDLE) | (state != IDLE).
  - Hits therefore complete with zero stall cycles.
- READ and WRITE both high: treated as READ; no store is performed.
- State machine:
  - IDLE:
    - read hit: no state change.
    - write hit: at posedge, the byte is written, dirty=1, state stays IDLE.
    - miss with valid & dirty: go to WRITEBACK.
    - miss otherwise: go to FETCH.
    - no access: no change.
  - WRITEBACK:
    - MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=data[index], held stable.
    - At the first posedge with MEM_BUSYWAIT=0: go to FETCH.
  - FETCH:
    - MEM_READ=1, MEM_ADDRESS={ADDRESS[7:5], index}.
    - At the first posedge with MEM_BUSYWAIT=0: data[index]=MEM_READDATA, tag=ADDRESS[7:5], valid=1, dirty=0, then go to IDLE.
- After FETCH completes, the pending access is a hit in IDLE on the next cycle. A pending write then stores its byte at the following posedge and sets dirty.
- MEM_READ and MEM_WRITE are never high together, and both are 0 in IDLE.
- The posedge that enters WRITEBACK or FETCH does not count as a memory completion. Minimum miss cost: 1 cycle per memory phase.
- MEM_BUSYWAIT held high indefinitely: the block stays in its current state with requests asserted.
- The CPU must hold ADDRESS, READ, WRITE and WRITEDATA stable while BUSYWAIT=1. Behaviour otherwise is undefined.
- Wrap-around: none. Index and offset are direct bit slices.

Test Plan:
- Reset, then READ addr 0x25 with memory block 0x09 = 0x44332211 and 3-cycle memory latency:
  - BUSYWAIT=1 immediately.
  - MEM_READ=1 with MEM_ADDRESS=0x09.
  - After completion and the hit cycle: READDATA=0x22, BUSYWAIT=0.
  - MEM_WRITE is never asserted.
- READ 0x24 right after the previous scenario -> hit: BUSYWAIT stays 0, READDATA=0x11 the same cycle, no memory request.
- WRITE 0xAB to 0x26 (hit) -> no stall. Then READ 0x26 -> 0xAB, and set 1 is dirty.
- Then READ 0x46 (same index, tag 2):
  - WRITEBACK with MEM_ADDRESS=0x09, MEM_WRITEDATA=0x44AB2211.
  - Then FETCH with MEM_ADDRESS=0x11.
  - Final READDATA equals byte 2 of block 0x11.
- Assert RESET during FETCH while MEM_BUSYWAIT=1:
  - Next cycle: MEM_READ=0, state IDLE, all sets invalid.
  - A held READ restarts as a miss with MEM_ADDRESS re-driven.
- READ and WRITE both 1 on a hit -> READDATA returned, the stored byte is unchanged, and dirty is not set.
